// File: rtl/commit_trace_serializer.sv
// Commit trace serializer: compacts up to RETIRE_WIDTH retiring instructions per cycle into a
// record queue and streams them out one record per ready/valid handshake.
module commit_trace_serializer #(
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned VLEN         = 256,
  parameter int unsigned ADDR_BITS    = 40,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                trace_enable,
  input  logic [RETIRE_WIDTH-1:0]             commit_valid,
  input  logic [RETIRE_WIDTH*ADDR_BITS-1:0]   commit_pc,
  input  logic [RETIRE_WIDTH*32-1:0]          commit_inst,
  input  logic [RETIRE_WIDTH*5-1:0]           commit_ldst,
  input  logic [RETIRE_WIDTH*3-1:0]           commit_rtype,
  input  logic [RETIRE_WIDTH*XLEN-1:0]        commit_wdata,
  input  logic [RETIRE_WIDTH*VLEN*8-1:0]      commit_vec_wdata,
  input  logic [RETIRE_WIDTH*8-1:0]           commit_vec_wmask,
  output logic                                commit_stall,
  output logic                                trace_valid,
  input  logic                                trace_ready,
  output logic [ADDR_BITS-1:0]                trace_pc,
  output logic [31:0]                         trace_inst,
  output logic [4:0]                          trace_ldst,
  output logic [2:0]                          trace_rtype,
  output logic [XLEN-1:0]                     trace_wdata,
  output logic [VLEN*8-1:0]                   trace_vec_wdata,
  output logic [7:0]                          trace_vec_wmask,
  output logic [31:0]                         trace_seq,
  output logic [15:0]                         overflow_cnt,
  output logic [$clog2(DEPTH):0]              occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned VecW = VLEN * 8;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [OccW-1:0] occ_t;

  // Payload storage is never reset; only the bookkeeping below is.
  logic [ADDR_BITS-1:0] pc_mem    [DEPTH];
  logic [31:0]          inst_mem  [DEPTH];
  logic [4:0]           ldst_mem  [DEPTH];
  logic [2:0]           rtype_mem [DEPTH];
  logic [XLEN-1:0]      wdata_mem [DEPTH];
  logic [VecW-1:0]      vdata_mem [DEPTH];
  logic [7:0]           vmask_mem [DEPTH];
  logic [31:0]          seq_mem   [DEPTH];

  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  occ_t        occ_q, occ_d;
  logic [31:0] seq_q, seq_d;
  logic [15:0] ovf_q, ovf_d;

  ptr_t        slot_idx [RETIRE_WIDTH];
  logic [31:0] slot_seq [RETIRE_WIDTH];
  occ_t        n_valid;
  occ_t        free;
  logic        want, accept, drop, deq;

  // Each valid slot lands at wr_ptr plus the number of valid slots below it.
  always_comb begin
    occ_t cnt;
    cnt = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      slot_idx[i] = wr_ptr_q + cnt[PtrW-1:0];
      slot_seq[i] = seq_q + 32'(cnt);
      cnt         = cnt + occ_t'(commit_valid[i]);
    end
    n_valid = cnt;
  end

  always_comb begin
    free   = occ_t'(DEPTH) - occ_q;
    want   = trace_enable && (n_valid != '0);
    accept = want && (free >= n_valid);
    drop   = want && !accept;
    deq    = (occ_q != '0) && trace_ready;

    occ_d    = occ_q + (accept ? n_valid : '0) - occ_t'(deq);
    wr_ptr_d = accept ? wr_ptr_q + n_valid[PtrW-1:0] : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    seq_d    = accept ? seq_q + 32'(n_valid) : seq_q;
    ovf_d    = (drop && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      seq_q    <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (commit_valid[i]) begin
          pc_mem[slot_idx[i]]    <= commit_pc[i*ADDR_BITS +: ADDR_BITS];
          inst_mem[slot_idx[i]]  <= commit_inst[i*32 +: 32];
          ldst_mem[slot_idx[i]]  <= commit_ldst[i*5 +: 5];
          rtype_mem[slot_idx[i]] <= commit_rtype[i*3 +: 3];
          wdata_mem[slot_idx[i]] <= commit_wdata[i*XLEN +: XLEN];
          vdata_mem[slot_idx[i]] <= commit_vec_wdata[i*VecW +: VecW];
          vmask_mem[slot_idx[i]] <= commit_vec_wmask[i*8 +: 8];
          seq_mem[slot_idx[i]]   <= slot_seq[i];
        end
      end
    end
  end

  always_comb begin
    trace_valid     = (occ_q != '0);
    commit_stall    = (free < occ_t'(RETIRE_WIDTH));
    occupancy       = occ_q;
    overflow_cnt    = ovf_q;
    trace_pc        = pc_mem[rd_ptr_q];
    trace_inst      = inst_mem[rd_ptr_q];
    trace_ldst      = ldst_mem[rd_ptr_q];
    trace_rtype     = rtype_mem[rd_ptr_q];
    trace_wdata     = wdata_mem[rd_ptr_q];
    trace_vec_wdata = vdata_mem[rd_ptr_q];
    trace_vec_wmask = vmask_mem[rd_ptr_q];
    // Sequence reads as zero when empty so it is defined straight out of reset.
    trace_seq       = trace_valid ? seq_mem[rd_ptr_q] : 32'd0;
  end

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Bench for commit_trace_serializer: directed table, corner-case sequences and a randomized
// run against a queue-based reference model.
module tb_commit_trace_serializer;

  localparam int unsigned RW    = 2;
  localparam int unsigned XL    = 64;
  localparam int unsigned VL    = 256;
  localparam int unsigned AB    = 40;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned VW    = VL * 8;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               trace_enable = 1'b0;
  logic [RW-1:0]      commit_valid = '0;
  logic [RW*AB-1:0]   commit_pc = '0;
  logic [RW*32-1:0]   commit_inst = '0;
  logic [RW*5-1:0]    commit_ldst = '0;
  logic [RW*3-1:0]    commit_rtype = '0;
  logic [RW*XL-1:0]   commit_wdata = '0;
  logic [RW*VW-1:0]   commit_vec_wdata = '0;
  logic [RW*8-1:0]    commit_vec_wmask = '0;
  logic               trace_ready = 1'b0;
  logic               commit_stall, trace_valid;
  logic [AB-1:0]      trace_pc;
  logic [31:0]        trace_inst;
  logic [4:0]         trace_ldst;
  logic [2:0]         trace_rtype;
  logic [XL-1:0]      trace_wdata;
  logic [VW-1:0]      trace_vec_wdata;
  logic [7:0]         trace_vec_wmask;
  logic [31:0]        trace_seq;
  logic [15:0]        overflow_cnt;
  logic [$clog2(DEPTH):0] occupancy;

  commit_trace_serializer #(
    .RETIRE_WIDTH(RW), .XLEN(XL), .VLEN(VL), .ADDR_BITS(AB), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .trace_enable(trace_enable),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_ldst(commit_ldst), .commit_rtype(commit_rtype), .commit_wdata(commit_wdata),
    .commit_vec_wdata(commit_vec_wdata), .commit_vec_wmask(commit_vec_wmask),
    .commit_stall(commit_stall), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_ldst(trace_ldst),
    .trace_rtype(trace_rtype), .trace_wdata(trace_wdata), .trace_vec_wdata(trace_vec_wdata),
    .trace_vec_wmask(trace_vec_wmask), .trace_seq(trace_seq), .overflow_cnt(overflow_cnt),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AB-1:0] pc;
    logic [31:0]   inst;
    logic [4:0]    ldst;
    logic [2:0]    rtype;
    logic [XL-1:0] wdata;
    logic [VW-1:0] vdata;
    logic [7:0]    vmask;
    logic [31:0]   seq;
  } rec_t;

  typedef struct {
    logic          en;
    logic [1:0]    valid;
    logic [AB-1:0] pc0;
    logic [AB-1:0] pc1;
    logic          rdy;
    logic          e_valid;
    int            e_occ;
    logic [AB-1:0] e_pc;
    logic [31:0]   e_seq;
  } vec_t;

  rec_t        mq[$];
  logic [31:0] m_seq;
  logic [15:0] m_ovf;
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid", 64'(trace_valid), 64'(mq.size() != 0));
    chk("m_occ", 64'(occupancy), 64'(mq.size()));
    chk("m_stall", 64'(commit_stall), 64'((DEPTH - mq.size()) < RW));
    chk("m_ovf", 64'(overflow_cnt), 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("m_pc", 64'(trace_pc), 64'(mq[0].pc));
      chk("m_inst", 64'(trace_inst), 64'(mq[0].inst));
      chk("m_ldst", 64'(trace_ldst), 64'(mq[0].ldst));
      chk("m_rtype", 64'(trace_rtype), 64'(mq[0].rtype));
      chk("m_wdata", trace_wdata, mq[0].wdata);
      chk("m_vmask", 64'(trace_vec_wmask), 64'(mq[0].vmask));
      chk("m_seq", 64'(trace_seq), 64'(mq[0].seq));
      n_cmp++;
      if (trace_vec_wdata !== mq[0].vdata) begin
        n_fail++;
        $display("FAIL m_vdata: got low %0h expected low %0h", trace_vec_wdata[63:0],
                 mq[0].vdata[63:0]);
      end
    end else begin
      chk("m_seq_empty", 64'(trace_seq), 64'd0);
    end
  endtask

  // One clock: the model applies the edge's rules to the inputs present at that edge.
  task automatic step();
    int  n;
    int  free;
    rec_t r;
    @(posedge clock);
    n = 0;
    for (int s = 0; s < RW; s++) n += int'(commit_valid[s]);
    free = DEPTH - mq.size();
    if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
    if (trace_enable && n > 0) begin
      if (free >= n) begin
        for (int s = 0; s < RW; s++) begin
          if (commit_valid[s]) begin
            r.pc    = commit_pc[s*AB +: AB];
            r.inst  = commit_inst[s*32 +: 32];
            r.ldst  = commit_ldst[s*5 +: 5];
            r.rtype = commit_rtype[s*3 +: 3];
            r.wdata = commit_wdata[s*XL +: XL];
            r.vdata = commit_vec_wdata[s*VW +: VW];
            r.vmask = commit_vec_wmask[s*8 +: 8];
            r.seq   = m_seq;
            m_seq   = m_seq + 32'd1;
            mq.push_back(r);
          end
        end
      end else if (m_ovf != 16'hFFFF) begin
        m_ovf = m_ovf + 16'd1;
      end
    end
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ovf", 64'(overflow_cnt), 64'd0);
    chk("rst_stall", 64'(commit_stall), 64'd0);
    chk("rst_seq", 64'(trace_seq), 64'd0);
    mq.delete();
    m_seq = 32'd0;
    m_ovf = 16'd0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic set_simple(input logic en, input logic [1:0] v, input logic [AB-1:0] p0,
                            input logic [AB-1:0] p1, input logic rdy);
    trace_enable     = en;
    commit_valid     = v;
    commit_pc        = {p1, p0};
    commit_inst      = '0;
    commit_ldst      = '0;
    commit_rtype     = '0;
    commit_wdata     = '0;
    commit_vec_wdata = '0;
    commit_vec_wmask = '0;
    trace_ready      = rdy;
  endtask

  task automatic drive_rand(input int rdy_pct);
    trace_enable = ($urandom_range(0, 9) != 0);
    commit_valid = RW'($urandom());
    for (int s = 0; s < RW; s++) begin
      commit_pc[s*AB +: AB]     = AB'({$urandom(), $urandom()});
      commit_inst[s*32 +: 32]   = $urandom();
      commit_ldst[s*5 +: 5]     = 5'($urandom());
      commit_rtype[s*3 +: 3]    = 3'($urandom());
      commit_wdata[s*XL +: XL]  = {$urandom(), $urandom()};
      commit_vec_wmask[s*8 +: 8] = 8'($urandom());
    end
    for (int w = 0; w < int'(RW * VW / 32); w++) commit_vec_wdata[w*32 +: 32] = $urandom();
    trace_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 40'h1000, 40'h1004, 1'b1, 1'b1, 2, 40'h1000, 32'd0};
    tbl[1]  = '{1'b1, 2'b00, 40'h0,    40'h0,    1'b1, 1'b1, 1, 40'h1004, 32'd1};
    tbl[2]  = '{1'b1, 2'b00, 40'h0,    40'h0,    1'b1, 1'b0, 0, 40'h0,    32'd0};
    tbl[3]  = '{1'b1, 2'b10, 40'h0,    40'h2000, 1'b1, 1'b1, 1, 40'h2000, 32'd2};
    tbl[4]  = '{1'b1, 2'b00, 40'h0,    40'h0,    1'b1, 1'b0, 0, 40'h0,    32'd0};
    tbl[5]  = '{1'b0, 2'b11, 40'h3000, 40'h3004, 1'b1, 1'b0, 0, 40'h0,    32'd0};
    tbl[6]  = '{1'b0, 2'b11, 40'h3008, 40'h300c, 1'b0, 1'b0, 0, 40'h0,    32'd0};
    tbl[7]  = '{1'b1, 2'b01, 40'h4000, 40'h0,    1'b0, 1'b1, 1, 40'h4000, 32'd3};
    tbl[8]  = '{1'b1, 2'b11, 40'h5000, 40'h5004, 1'b0, 1'b1, 3, 40'h4000, 32'd3};
    tbl[9]  = '{1'b1, 2'b00, 40'h0,    40'h0,    1'b1, 1'b1, 2, 40'h5000, 32'd4};
    tbl[10] = '{1'b1, 2'b01, 40'h6000, 40'h0,    1'b1, 1'b1, 2, 40'h5004, 32'd5};
    tbl[11] = '{1'b1, 2'b00, 40'h0,    40'h0,    1'b1, 1'b1, 1, 40'h6000, 32'd6};
    tbl[12] = '{1'b1, 2'b00, 40'h0,    40'h0,    1'b1, 1'b0, 0, 40'h0,    32'd0};

    m_seq = 32'd0;
    m_ovf = 16'd0;
    do_reset();

    // Directed table: basic capture, compaction, disabled capture, stall hold, enq+deq.
    for (int i = 0; i < 13; i++) begin
      set_simple(tbl[i].en, tbl[i].valid, tbl[i].pc0, tbl[i].pc1, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_valid", i), 64'(trace_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow_cnt), 64'd0);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), 64'(trace_pc), 64'(tbl[i].e_pc));
        chk($sformatf("tbl%0d_seq", i), 64'(trace_seq), 64'(tbl[i].e_seq));
      end
    end

    // Fill to full with ready low, then one dropped commit.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_simple(1'b1, 2'b11, 40'h8000 + 40'(8 * k), 40'h8004 + 40'(8 * k), 1'b0);
      step();
      chk("fill_occ", 64'(occupancy), 64'(2 * (k + 1)));
    end
    chk("full_stall", 64'(commit_stall), 64'd1);
    set_simple(1'b1, 2'b11, 40'h9000, 40'h9004, 1'b0);
    step();
    chk("drop_ovf", 64'(overflow_cnt), 64'd1);
    chk("drop_occ", 64'(occupancy), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("drain_seq", 64'(trace_seq), 64'(k));
      set_simple(1'b1, 2'b00, 40'h0, 40'h0, 1'b1);
      step();
      if (k == 0) chk("occ7_stall", 64'(commit_stall), 64'd1);
    end

    // Refill to 5 and reset between edges with a transfer pending.
    set_simple(1'b1, 2'b11, 40'hA000, 40'hA004, 1'b0);
    step();
    step();
    set_simple(1'b1, 2'b01, 40'hA010, 40'h0, 1'b0);
    step();
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    chk("pre_rst_ovf", 64'(overflow_cnt), 64'd1);
    set_simple(1'b0, 2'b00, 40'h0, 40'h0, 1'b0);
    do_reset();
    set_simple(1'b1, 2'b01, 40'hB000, 40'h0, 1'b0);
    step();
    chk("post_rst_seq", 64'(trace_seq), 64'd0);
    chk("post_rst_pc", 64'(trace_pc), 64'hB000);
    set_simple(1'b1, 2'b00, 40'h0, 40'h0, 1'b1);
    step();

    // Sequence counter wrap: preload, let one idle edge latch it, then three captures.
    force dut.seq_q = 32'hFFFF_FFFE;
    step();
    release dut.seq_q;
    m_seq = 32'hFFFF_FFFE;
    set_simple(1'b1, 2'b01, 40'hC000, 40'h0, 1'b0);
    step();
    set_simple(1'b1, 2'b10, 40'h0, 40'hC004, 1'b0);
    step();
    set_simple(1'b1, 2'b01, 40'hC008, 40'h0, 1'b0);
    step();
    chk("wrap_seq0", 64'(trace_seq), 64'hFFFF_FFFE);
    set_simple(1'b1, 2'b00, 40'h0, 40'h0, 1'b1);
    step();
    chk("wrap_seq1", 64'(trace_seq), 64'hFFFF_FFFF);
    step();
    chk("wrap_seq2", 64'(trace_seq), 64'h0);
    chk("wrap_pc2", 64'(trace_pc), 64'hC008);
    step();

    // Randomized traffic under varying backpressure.
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 400; c++) begin
        drive_rand((blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 55 : 95));
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_serializer.md
COMMIT_TRACE_SERIALIZER -- requirements
Module: commit_trace_serializer

Interface
REQ-001 Parameter RETIRE_WIDTH, default 2: commit slots per cycle, legal 1..4.
REQ-002 Parameter XLEN, default 64: scalar writeback data width.
REQ-003 Parameter VLEN, default 256: vector register length; vector data is VLEN*8 bits per slot.
REQ-004 Parameter ADDR_BITS, default 40: PC width.
REQ-005 Parameter DEPTH, default 8: record queue entries, power of 2, >= 2*RETIRE_WIDTH.
REQ-006 Port clock, input, 1: sole clock, rising edge.
REQ-007 Port reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port trace_enable, input, 1: capture enable; queue still drains when low.
REQ-009 Port commit_valid, input, RETIRE_WIDTH: per-slot architectural commit valid.
REQ-010 Port commit_pc, input, RETIRE_WIDTH*ADDR_BITS: per-slot debug PC, slot i at bits [i*ADDR_BITS +: ADDR_BITS].
REQ-011 Ports commit_inst (32), commit_ldst (5), commit_rtype (3), commit_wdata (XLEN), commit_vec_wdata (VLEN*8), commit_vec_wmask (8): inputs, each width times RETIRE_WIDTH, packed as commit_pc.
REQ-012 Port commit_stall, output, 1: high when free entries < RETIRE_WIDTH.
REQ-013 Port trace_valid, output, 1; trace_ready, input, 1: output record handshake.
REQ-014 Ports trace_pc, trace_inst, trace_ldst, trace_rtype, trace_wdata, trace_vec_wdata, trace_vec_wmask: outputs, single-slot widths, head record fields.
REQ-015 Port trace_seq, output, 32: sequence number of head record.
REQ-016 Port overflow_cnt, output, 16: count of dropped commit cycles, saturating.
REQ-017 Port occupancy, output, log2(DEPTH)+1: entries held.

Function
REQ-018 Capture cycle: trace_enable high and popcount(commit_valid) = N > 0.
REQ-019 Valid slots SHALL be compacted and enqueued in ascending slot index order, all N in one cycle.
REQ-020 Enqueue SHALL proceed only if free entries, sampled at start of cycle and ignoring same-cycle dequeue, are >= N.
REQ-021 Otherwise all N records SHALL be dropped, none partially enqueued, and overflow_cnt incremented by 1, saturating at 16'hFFFF.
REQ-022 With trace_enable low, commits SHALL be ignored and SHALL not increment overflow_cnt.
REQ-023 trace_valid SHALL equal (occupancy != 0); trace_* fields SHALL come from the head entry register, not combinationally from commit_*.
REQ-024 Latency: a record captured in cycle N is presentable on trace_* from cycle N+1 at the earliest.
REQ-025 Dequeue SHALL occur when trace_valid and trace_ready are both high; trace_* SHALL hold stable while trace_valid and not trace_ready.
REQ-026 Simultaneous enqueue and dequeue SHALL give occupancy_next = occupancy + N - 1.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by occupancy, not pointer equality.
REQ-028 trace_seq SHALL be assigned at enqueue from a 32-bit counter that increments per record and wraps 0xFFFFFFFF -> 0; dropped records SHALL not consume sequence numbers.
REQ-029 commit_stall SHALL be combinational from current occupancy only.

Reset
REQ-030 Asserting reset_n low SHALL immediately clear pointers, occupancy, sequence counter and overflow_cnt, and drive trace_valid 0, commit_stall 0, trace_seq 0; queued records are discarded.
REQ-031 Queue payload storage SHALL need no reset; trace_* data fields SHALL be don't-care while trace_valid is 0.
REQ-032 Reset asserted mid-handshake SHALL abort the transfer; the first record after release SHALL carry trace_seq 0.

Verification
REQ-033 RETIRE_WIDTH=2, valid=2'b11, pc0=0x1000, pc1=0x1004, ready=1 -> trace_valid cycles N+1 and N+2 with pc 0x1000 then 0x1004, seq 0 then 1.
REQ-034 valid=2'b10, pc1=0x2000 -> single record pc 0x2000; occupancy peaks at 1.
REQ-035 ready=0, 2-slot commits every cycle, DEPTH=8 -> occupancy reaches 8 after 4 cycles, commit_stall high from occupancy 7, next commit dropped, overflow_cnt=1, trace_seq sequence 0..7 gap-free.
REQ-036 trace_enable=0 with valid=2'b11 -> no enqueue, overflow_cnt unchanged, trace_valid stays 0.
REQ-037 Preload trace_seq counter near 0xFFFFFFFE via 3 captures after forcing -> outputs seq 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-038 reset_n low while occupancy=5 and trace_valid=1, ready=0 -> same-instant trace_valid=0, occupancy=0, overflow_cnt=0.
